// File: rtl/cbus_mem_model_mp.sv
// Multi-port CBus memory model: round-robin arbiter feeding one shared burst engine over a word array.
// Optional macro RANDOM_LATENCY_EN: grant-to-first-beat wait drawn from a 16-bit LFSR instead of LATENCY.
module cbus_mem_model_mp #(
  parameter int          NPORT      = 2,
  parameter int          DW         = 32,
  parameter int          AW         = 32,
  parameter int          DEPTH      = 65536,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] MMIO_BASE  = 32'h2000_0000,
  parameter logic [31:0] MMIO_RDATA = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_is_write,
  input  logic [NPORT*3-1:0]      req_size,
  input  logic [NPORT*AW-1:0]     req_addr,
  input  logic [NPORT*8-1:0]      req_len,
  input  logic [NPORT*2-1:0]      req_burst,
  input  logic [NPORT*DW-1:0]     req_data,
  input  logic [NPORT*DW/8-1:0]   req_strobe,
  output logic [NPORT-1:0]        resp_ready,
  output logic [NPORT-1:0]        resp_last,
  output logic [NPORT*DW-1:0]     resp_data,
  output logic                    err,
  output logic [$clog2(NPORT):0]  err_port
);

  localparam int BPW  = DW / 8;
  localparam int OFFW = $clog2(BPW);
  localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int EW   = $clog2(NPORT) + 1;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_WRITE} state_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (int'(s) > OFFW) ? 3'(OFFW) : s;
  endfunction

  function automatic logic [AW-1:0] size_mask(input logic [2:0] s);
    return (AW'(1) << s) - AW'(1);
  endfunction

  // WRAP window is (len+1) beats, aligned to its own size around the burst start.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur, input logic [AW-1:0] base,
                                               input logic [7:0] len, input logic [2:0] s,
                                               input logic [1:0] bt);
    logic [AW-1:0] window, wbase, inc, res;
    window = (AW'(len) + AW'(1)) << s;
    wbase  = base & ~(window - AW'(1));
    inc    = cur + (AW'(1) << s);
    case (bt)
      2'd0:    res = cur;
      2'd2:    res = (inc == wbase + window) ? wbase : inc;
      default: res = inc;
    endcase
    return res;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = a >> OFFW;
    return IW'(w % AW'(DEPTH));
  endfunction

  function automatic logic is_mmio(input logic [AW-1:0] a);
    return a >= AW'(MMIO_BASE);
  endfunction

`ifdef RANDOM_LATENCY_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
`endif

  state_t          state, state_nx;
  logic [PW-1:0]   rr, grant, arb_port, err_src;
  logic            arb_hit;
  logic [15:0]     count, load_count;
  logic [7:0]      beat;
  logic [AW-1:0]   addr, start;

  logic            l_is_write;
  logic [2:0]      l_size, l_esize;
  logic [AW-1:0]   l_addr;
  logic [7:0]      l_len;
  logic [1:0]      l_burst;

  logic            a_is_write;
  logic [2:0]      a_size, a_esize;
  logic [AW-1:0]   a_addr;
  logic [7:0]      a_len;
  logic [1:0]      a_burst;

  logic            g_valid, g_is_write;
  logic [2:0]      g_size;
  logic [AW-1:0]   g_addr;
  logic [7:0]      g_len;
  logic [1:0]      g_burst;
  logic [DW-1:0]   g_data;
  logic [BPW-1:0]  g_strobe;

  logic [DW-1:0]   rd_data;
  logic            err_grant, err_hold, err_now;
  logic            in_beat;

  logic [DW-1:0]   mem [DEPTH];

`ifdef RANDOM_LATENCY_EN
  logic [15:0] lfsr;
  assign load_count = {11'd0, lfsr[4:0]} + 16'd1;
`else
  assign load_count = 16'(LATENCY);
`endif

  // Round-robin: first valid port at or after the rr pointer.
  always_comb begin
    int p;
    p        = 0;
    arb_hit  = 1'b0;
    arb_port = '0;
    for (int i = 0; i < NPORT; i++) begin
      p = (int'(rr) + i) % NPORT;
      if (!arb_hit && req_valid[p]) begin
        arb_hit  = 1'b1;
        arb_port = PW'(p);
      end
    end
  end

  assign a_is_write = req_is_write[arb_port];
  assign a_size     = req_size[arb_port*3 +: 3];
  assign a_addr     = req_addr[arb_port*AW +: AW];
  assign a_len      = req_len[arb_port*8 +: 8];
  assign a_burst    = req_burst[arb_port*2 +: 2];
  assign a_esize    = clamp_size(a_size);

  assign g_valid    = req_valid[grant];
  assign g_is_write = req_is_write[grant];
  assign g_size     = req_size[grant*3 +: 3];
  assign g_addr     = req_addr[grant*AW +: AW];
  assign g_len      = req_len[grant*8 +: 8];
  assign g_burst    = req_burst[grant*2 +: 2];
  assign g_data     = req_data[grant*DW +: DW];
  assign g_strobe   = req_strobe[grant*BPW +: BPW];

  assign in_beat = (state == S_READ) || (state == S_WRITE);

  assign err_grant = (state == S_IDLE) && arb_hit &&
                     (((a_addr & size_mask(a_esize)) != '0) || (int'(a_size) > OFFW) ||
                      (a_burst == 2'd3));
  assign err_hold  = (state != S_IDLE) &&
                     (!g_valid || (g_is_write != l_is_write) || (g_size != l_size) ||
                      (g_addr != l_addr) || (g_len != l_len) || (g_burst != l_burst));
  assign err_now   = err_grant || err_hold;
  assign err_src   = (state == S_IDLE) ? arb_port : grant;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          if (load_count == 16'd0) state_nx = a_is_write ? S_WRITE : S_READ;
          else                     state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count <= 16'd1) state_nx = l_is_write ? S_WRITE : S_READ;
      end
      S_READ, S_WRITE: begin
        if (beat == 8'd0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Control: grant, counters, rr pointer and the sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr       <= '0;
      grant    <= '0;
      count    <= '0;
      beat     <= '0;
      err      <= 1'b0;
      err_port <= '0;
`ifdef RANDOM_LATENCY_EN
      lfsr     <= 16'hACE1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_hit) begin
            grant <= arb_port;
            count <= load_count;
            beat  <= a_len;
`ifdef RANDOM_LATENCY_EN
            lfsr  <= lfsr_step(lfsr);
`endif
          end
        end
        S_WAIT: count <= count - 16'd1;
        S_READ, S_WRITE: begin
          if (beat == 8'd0) rr   <= PW'((int'(grant) + 1) % NPORT);
          else              beat <= beat - 8'd1;
        end
        default: ;
      endcase
      if (err_now) begin
        err <= 1'b1;
        if (!err) err_port <= EW'(err_src);
      end
    end
  end

  // Request capture and beat address; the start is aligned down to the beat size.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && arb_hit) begin
      l_is_write <= a_is_write;
      l_size     <= a_size;
      l_esize    <= a_esize;
      l_addr     <= a_addr;
      l_len      <= a_len;
      l_burst    <= a_burst;
      start      <= a_addr & ~size_mask(a_esize);
      addr       <= a_addr & ~size_mask(a_esize);
    end else if (in_beat && beat != 8'd0) begin
      addr <= next_addr(addr, start, l_len, l_esize, l_burst);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == S_WRITE && !is_mmio(addr)) begin
      for (int b = 0; b < BPW; b++) begin
        if (g_strobe[b]) mem[word_idx(addr)][8*b +: 8] <= g_data[8*b +: 8];
      end
    end
  end

  assign rd_data = is_mmio(addr) ? DW'(MMIO_RDATA) : mem[word_idx(addr)];

  always_comb begin
    resp_ready = '0;
    resp_last  = '0;
    resp_data  = '0;
    if (reset && in_beat) begin
      resp_ready[grant] = 1'b1;
      resp_last[grant]  = (beat == 8'd0);
      if (state == S_READ) resp_data[grant*DW +: DW] = rd_data;
    end
  end

endmodule

// File: tb/tb_cbus_mem_model_mp.sv
// Scoreboard bench for cbus_mem_model_mp: drivers push expected beats, a negedge monitor pops and compares.
module tb_cbus_mem_model_mp;
  localparam int NPORT   = 2;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NPORT-1:0]      req_valid, req_is_write, resp_ready, resp_last;
  logic [NPORT*3-1:0]    req_size;
  logic [NPORT*AW-1:0]   req_addr;
  logic [NPORT*8-1:0]    req_len;
  logic [NPORT*2-1:0]    req_burst;
  logic [NPORT*DW-1:0]   req_data, resp_data;
  logic [NPORT*DW/8-1:0] req_strobe;
  logic                  err;
  logic [$clog2(NPORT):0] err_port;

  logic        p_valid [NPORT];
  logic        p_wr    [NPORT];
  logic [2:0]  p_size  [NPORT];
  logic [31:0] p_addr  [NPORT];
  logic [7:0]  p_len   [NPORT];
  logic [1:0]  p_burst [NPORT];
  logic [31:0] p_data  [NPORT];
  logic [3:0]  p_strb  [NPORT];

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign req_valid[g]            = p_valid[g];
    assign req_is_write[g]         = p_wr[g];
    assign req_size[g*3 +: 3]      = p_size[g];
    assign req_addr[g*AW +: AW]    = p_addr[g];
    assign req_len[g*8 +: 8]       = p_len[g];
    assign req_burst[g*2 +: 2]     = p_burst[g];
    assign req_data[g*DW +: DW]    = p_data[g];
    assign req_strobe[g*4 +: 4]    = p_strb[g];
  end

  cbus_mem_model_mp #(.NPORT(NPORT), .DW(DW), .AW(AW), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_size(req_size),
    .req_addr(req_addr), .req_len(req_len), .req_burst(req_burst),
    .req_data(req_data), .req_strobe(req_strobe),
    .resp_ready(resp_ready), .resp_last(resp_last), .resp_data(resp_data),
    .err(err), .err_port(err_port)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        chk;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   lat0, lat1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic push(input int p, input logic [31:0] d, input logic c, input logic l);
    exp_t e;
    e.port = p; e.data = d; e.chk = c; e.last = l;
    sbq.push_back(e);
  endtask

  // Monitor: every ready beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) begin
        if (resp_ready[i]) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat port=%0d data=%h want=no_beat", i, resp_data[i*DW +: DW]);
          end else begin
            mon_e = sbq.pop_front();
            if (mon_e.port != i || mon_e.last !== resp_last[i] ||
                (mon_e.chk && resp_data[i*DW +: DW] !== mon_e.data)) begin
              failures++;
              $display("FAIL beat port=%0d data=%h last=%0b want port=%0d data=%h last=%0b",
                       i, resp_data[i*DW +: DW], resp_last[i], mon_e.port, mon_e.data, mon_e.last);
            end
          end
        end
      end
    end
  end

  // Issue one burst on port p and hold it until its last beat; beat k writes wd0+k*step.
  task automatic burst(input int p, input logic wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] bt, input logic [31:0] wd0, input logic [31:0] step,
                       input logic [3:0] strb, input int corrupt_at, output int lat);
    int beat, cyc;
    bit done;
    p_wr[p] = wr; p_size[p] = 3'd2; p_addr[p] = addr; p_len[p] = len; p_burst[p] = bt;
    p_data[p] = wd0; p_strb[p] = strb; p_valid[p] = 1'b1;
    beat = 0; cyc = 0; lat = -1; done = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (resp_ready[p]) begin
        if (beat == 0) lat = cyc;
        p_data[p] = wd0 + 32'(beat) * step;
        if (beat == corrupt_at) p_addr[p] = addr ^ 32'h40;
        if (resp_last[p]) done = 1;
        beat++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout port=%0d got_beats=%0d want_beats=%0d", p, beat, int'(len) + 1);
    end
    @(posedge clk);
    #1;
    p_valid[p] = 1'b0;
    p_addr[p]  = addr;
  endtask

  initial begin
    for (int i = 0; i < NPORT; i++) begin
      p_valid[i] = 0; p_wr[i] = 0; p_size[i] = 3'd2; p_addr[i] = '0; p_len[i] = '0;
      p_burst[i] = 2'd1; p_data[i] = '0; p_strb[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(resp_ready), 64'd0);
    chk("reset_last", 64'(resp_last), 64'd0);
    chk("reset_data", 64'(resp_data), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_err_port", 64'(err_port), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Preload 0x100..0x10C with 1,2,3,4, then read back INCR and check grant latency.
    for (int k = 0; k < 4; k++) push(0, 32'd0, 1'b0, k == 3);
    burst(0, 1'b1, 32'h100, 8'd3, 2'd1, 32'd1, 32'd1, 4'hF, -1, lat0);
    for (int k = 0; k < 4; k++) push(0, 32'(k + 1), 1'b1, k == 3);
    burst(0, 1'b0, 32'h100, 8'd3, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
    chk("read_latency", 64'(lat0), 64'(LATENCY + 2));
    chk("err_after_incr", 64'(err), 64'd0);

    // WRAP from 0x108 visits 0x108,0x10C,0x100,0x104.
    push(0, 32'd3, 1'b1, 1'b0); push(0, 32'd4, 1'b1, 1'b0);
    push(0, 32'd1, 1'b1, 1'b0); push(0, 32'd2, 1'b1, 1'b1);
    burst(0, 1'b0, 32'h108, 8'd3, 2'd2, 32'd0, 32'd0, 4'h0, -1, lat0);

    // Partial-strobe write on port1.
    push(1, 32'd0, 1'b0, 1'b1);
    burst(1, 1'b1, 32'h200, 8'd0, 2'd1, 32'h1122_3344, 32'd0, 4'hF, -1, lat1);
    push(1, 32'd0, 1'b0, 1'b1);
    burst(1, 1'b1, 32'h200, 8'd0, 2'd1, 32'hDEAD_BEEF, 32'd0, 4'h3, -1, lat1);
    push(1, 32'h1122_BEEF, 1'b1, 1'b1);
    burst(1, 1'b0, 32'h200, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat1);

    // Simultaneous requests with rr=0: port0 first.
    push(0, 32'd1, 1'b1, 1'b1);
    push(1, 32'h1122_BEEF, 1'b1, 1'b1);
    fork
      burst(0, 1'b0, 32'h100, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
      burst(1, 1'b0, 32'h200, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat1);
    join
    // One port0 burst moves rr to 1, so the next simultaneous pair serves port1 first.
    push(0, 32'd2, 1'b1, 1'b1);
    burst(0, 1'b0, 32'h104, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
    push(1, 32'h1122_BEEF, 1'b1, 1'b1);
    push(0, 32'd4, 1'b1, 1'b1);
    fork
      burst(0, 1'b0, 32'h10C, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
      burst(1, 1'b0, 32'h200, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat1);
    join

    // MMIO read value, and an MMIO write that must not alias onto word 0.
    push(0, 32'h0000_0001, 1'b1, 1'b1);
    burst(0, 1'b0, 32'h2000_0004, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
    push(0, 32'd0, 1'b0, 1'b1);
    burst(0, 1'b1, 32'h0, 8'd0, 2'd1, 32'hA5A5_0000, 32'd0, 4'hF, -1, lat0);
    push(0, 32'd0, 1'b0, 1'b1);
    burst(0, 1'b1, 32'h2000_0000, 8'd0, 2'd1, 32'hFFFF_FFFF, 32'd0, 4'hF, -1, lat0);
    push(0, 32'hA5A5_0000, 1'b1, 1'b1);
    burst(0, 1'b0, 32'h0, 8'd0, 2'd1, 32'd0, 32'd0, 4'h0, -1, lat0);
    chk("err_before_violation", 64'(err), 64'd0);

    // Port0 changes its address mid-burst; the burst still completes from the latched address.
    for (int k = 0; k < 4; k++) push(0, 32'(k + 1), 1'b1, k == 3);
    burst(0, 1'b0, 32'h100, 8'd3, 2'd1, 32'd0, 32'd0, 4'h0, 1, lat0);
    chk("err_mid_burst", 64'(err), 64'd1);
    chk("err_port_first", 64'(err_port), 64'd0);

    // Burst code 3 from port1 acts as INCR and leaves the first err_port in place.
    push(1, 32'd1, 1'b1, 1'b0); push(1, 32'd2, 1'b1, 1'b1);
    burst(1, 1'b0, 32'h100, 8'd1, 2'd3, 32'd0, 32'd0, 4'h0, -1, lat1);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_port_held", 64'(err_port), 64'd0);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("err_cleared", 64'(err), 64'd0);
    chk("err_port_cleared", 64'(err_port), 64'd0);
    reset = 1'b1;

    for (int w = 0; w < 20 && sbq.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
